uart_rx_fifo: RTL and testbench

- Downstream consumer of the UART receiver.
- Watches the receiver's byte-ready flag, captures each received byte into an on-chip FIFO, and returns the ready-clear pulse to the receiver.
- Presents the buffered bytes to the host side as a first-word-fall-through valid/ready stream.
- Reports occupancy plus a sticky overrun flag for bytes dropped when the FIFO is full.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_rx_fifo.sv | 78 +++++++
 tb/tb_uart_rx_fifo.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } cap_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side byte handshake plus host-side FWFT stream.
interface uart_rx_fifo_if import uart_pkg::*;;

  logic [DATA_W-1:0] rx_data;
  logic              rx_rdy;
  logic              rx_rdy_clr;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output rx_data, rx_rdy, m_ready,
    input  rx_rdy_clr, m_data, m_valid
  );

  modport slave (
    input  rx_data, rx_rdy, m_ready,
    output rx_rdy_clr, m_data, m_valid
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; caller gates wr_en/rd_en against full/empty.
module uart_sync_fifo import uart_pkg::*; #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  always_ff @(posedge clk_50m) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; contents are only observable behind a valid count.
  always_ff @(posedge clk_50m) begin
    if (wr_en && !flush && !rst) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures bytes from the UART receiver into a FIFO and streams them to the host.
//   state | meaning
//   IDLE  | waiting for rx_rdy; a high rx_rdy here is a new byte
//   CLEAR | rx_rdy_clr pulse is out; rx_rdy still shows the old byte and is ignored
module uart_rx_fifo import uart_pkg::*; #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic            clk_50m,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus,
  input  logic            flush,
  input  logic            ovr_clr,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            overrun
);

  cap_state_t state;
  logic       rdy_clr_q;
  logic       empty;
  logic       capture;
  logic       rd_fire;
  logic       wr_ok;
  logic       wr_en;
  logic       drop;

  assign rd_fire = !empty && bus.m_ready;
  assign capture = (state == IDLE) && bus.rx_rdy;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign wr_ok   = !full || rd_fire;
  assign wr_en   = capture && wr_ok && !flush;
  assign drop    = capture && !wr_ok && !flush;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_50m (clk_50m),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (bus.rx_data),
    .rd_en   (rd_fire),
    .rd_data (bus.m_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state     <= IDLE;
      rdy_clr_q <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rx_rdy) begin
            rdy_clr_q <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          rdy_clr_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rdy_clr_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign bus.rx_rdy_clr = rdy_clr_q;
  assign bus.m_valid    = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a receiver model that drops rx_rdy on rx_rdy_clr.
module tb_uart_rx_fifo;

  logic       clk_50m;
  logic       rst;
  logic       flush;
  logic       ovr_clr;
  logic [4:0] count;
  logic       full;
  logic       overrun;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus),
    .flush   (flush),
    .ovr_clr (ovr_clr),
    .count   (count),
    .full    (full),
    .overrun (overrun)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  int tests  = 0;
  int failed = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       mr;
    logic       fl;
    logic       oc;
    logic       e_clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_ovr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver: raises rx_rdy with the next byte, and on a clear either loads the next byte or drops rx_rdy.
  task automatic send(input logic [7:0] b);
    if (!bus.rx_rdy) begin
      bus.rx_data = b;
      bus.rx_rdy  = 1'b1;
    end else begin
      rx_q.push_back(b);
    end
  endtask

  task automatic step();
    logic clr_seen;
    clr_seen = bus.rx_rdy_clr;
    @(posedge clk_50m);
    #1;
    if (clr_seen) begin
      if (rx_q.size() > 0) bus.rx_data = rx_q.pop_front();
      else                 bus.rx_rdy  = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain_check(input string name, input int n, input logic [7:0] base, input logic [7:0] last);
    logic [7:0] e;
    bus.m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = (i == n - 1) ? last : base + 8'(i);
      chk({name, "_valid"}, bus.m_valid, 1'b1);
      chk({name, "_data"}, bus.m_data, e);
      step();
    end
    bus.m_ready = 1'b0;
    chk({name, "_empty"}, count, 5'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int rcv;
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    rst         = 1'b1;
    flush       = 1'b0;
    ovr_clr     = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_rdy  = 1'b0;
    bus.m_ready = 1'b0;
    steps(2);
    chk("rst_clr", bus.rx_rdy_clr, 1'b0);
    chk("rst_valid", bus.m_valid, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    step();

    // Single byte, empty write+read, back-to-back 0x11/0x22, flush during capture.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].push) send(vecs[i].din);
      bus.m_ready = vecs[i].mr;
      flush       = vecs[i].fl;
      ovr_clr     = vecs[i].oc;
      step();
      chk($sformatf("vec%0d_clr", i), bus.rx_rdy_clr, vecs[i].e_clr);
      chk($sformatf("vec%0d_valid", i), bus.m_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), bus.m_data, vecs[i].e_data);
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
      chk($sformatf("vec%0d_ovr", i), overrun, vecs[i].e_ovr);
    end
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    ovr_clr     = 1'b0;

    // Fill with 17 bytes; the 17th is dropped.
    for (int i = 0; i < 17; i++) send(8'(i));
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 28) begin
        chk("fill15_count", count, 5'd15);
        chk("fill15_full", full, 1'b0);
      end
      if (i == 30) begin
        chk("fill16_count", count, 5'd16);
        chk("fill16_full", full, 1'b1);
        chk("fill16_ovr", overrun, 1'b0);
      end
    end
    chk("fill_count", count, 5'd16);
    chk("fill_ovr", overrun, 1'b1);

    // Drop and clear in the same cycle: the drop wins.
    ovr_clr = 1'b1;
    send(8'h20);
    step();
    ovr_clr = 1'b0;
    chk("setwins_ovr", overrun, 1'b1);
    chk("setwins_count", count, 5'd16);
    step();
    drain_check("drain_fill", 16, 8'h00, 8'h0F);
    chk("drain_ovr_kept", overrun, 1'b1);

    // Flush with 5 queued bytes leaves overrun alone.
    for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i));
    steps(12);
    chk("pre_flush_count", count, 5'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", count, 5'd0);
    chk("flush_valid", bus.m_valid, 1'b0);
    chk("flush_ovr", overrun, 1'b1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);

    // Full FIFO, read and capture in the same cycle.
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    steps(34);
    chk("full2_count", count, 5'd16);
    bus.m_ready = 1'b1;
    send(8'h55);
    step();
    bus.m_ready = 1'b0;
    chk("fullrd_count", count, 5'd16);
    chk("fullrd_full", full, 1'b1);
    chk("fullrd_ovr", overrun, 1'b0);
    step();
    drain_check("drain_fullrd", 16, 8'h31, 8'h55);

    // Streaming 40 bytes with a random ready; pointers wrap several times.
    for (int i = 0; i < 40; i++) begin
      send(8'h80 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
    end
    sent = 40;
    rcv  = 0;
    for (int c = 0; c < 500 && rcv < sent; c++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if (bus.m_valid && bus.m_ready && exp_q.size() > 0) begin
        chk($sformatf("wrap_data%0d", rcv), bus.m_data, exp_q.pop_front());
        rcv++;
      end
      step();
      chk("wrap_count_range", count <= 5'd16, 1'b1);
    end
    bus.m_ready = 1'b0;
    chk("wrap_received", rcv, 40);
    chk("wrap_ovr", overrun, 1'b0);
    chk("wrap_empty", count, 5'd0);
    steps(2);

    // Reset while in CLEAR.
    send(8'h77);
    step();
    chk("rclr_pulse", bus.rx_rdy_clr, 1'b1);
    chk("rclr_count", count, 5'd1);
    rst = 1'b1;
    step();
    chk("rclr_rst_clr", bus.rx_rdy_clr, 1'b0);
    chk("rclr_rst_count", count, 5'd0);
    chk("rclr_rst_valid", bus.m_valid, 1'b0);
    bus.rx_data = 8'h78;
    bus.rx_rdy  = 1'b1;
    step();
    chk("rclr_hold_clr", bus.rx_rdy_clr, 1'b0);
    chk("rclr_hold_count", count, 5'd0);
    rst = 1'b0;
    step();
    chk("rclr_cap_clr", bus.rx_rdy_clr, 1'b1);
    chk("rclr_cap_count", count, 5'd1);
    chk("rclr_cap_data", bus.m_data, 8'h78);
    step();
    chk("rclr_end_clr", bus.rx_rdy_clr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
